// File: rtl/uart_rx_packet_controller.sv
// Pulls bytes from the UART RX FIFO, parses SOF/LEN/payload/CHK frames, buffers the
// payload until the XOR checksum is confirmed, then streams it out on valid/ready.
module uart_rx_packet_controller #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] rx_data,
  input  logic       parity_error,
  input  logic       framing_error,
  input  logic       rx_overflow_error,
  output logic       fifo_read,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic [7:0] pkt_len,
  output logic       frame_error,
  output logic       timeout_error,
  output logic [7:0] pkt_ok_count,
  output logic [7:0] pkt_err_count,
  output logic       busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN8 = MAX_LEN[7:0];
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {HUNT, GET_LEN, GET_PAY, GET_CHK, SEND} state_t;

  state_t        state;
  logic          pending;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [7:0]    chk;
  logic [TW-1:0] tmo;
  logic [7:0]    buf_mem [0:(1<<AW)-1];

  logic       byte_err;
  logic       fetch_state;
  logic       counting;
  logic       tmo_fire;
  logic       abort;
  logic       buf_we;
  logic [7:0] idx_inc;
  logic [7:0] len_m1;

  assign byte_err    = parity_error | framing_error | rx_overflow_error;
  assign fetch_state = (state != SEND);
  assign counting    = (state == GET_LEN) || (state == GET_PAY) || (state == GET_CHK);
  assign idx_inc     = idx + 8'd1;
  assign len_m1      = len - 8'd1;
  assign busy        = (state != HUNT);

  // A capture always takes priority over an expiring timeout in the same cycle.
  assign tmo_fire = counting && !pending && (tmo == TMO_LAST);

  assign abort = pending &&
                 (((state == GET_LEN) && (byte_err || rx_data == 8'd0 || rx_data > MAX_LEN8)) ||
                  (((state == GET_PAY) || (state == GET_CHK)) && byte_err) ||
                  ((state == GET_CHK) && (rx_data != chk)));

  assign buf_we = pending && (state == GET_PAY) && !byte_err;

  always_ff @(posedge clk) begin
    if (buf_we)
      buf_mem[idx[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      pending       <= 1'b0;
      fifo_read     <= 1'b0;
      len           <= 8'd0;
      idx           <= 8'd0;
      chk           <= 8'd0;
      tmo           <= '0;
      pkt_data      <= 8'd0;
      pkt_valid     <= 1'b0;
      pkt_last      <= 1'b0;
      pkt_len       <= 8'd0;
      frame_error   <= 1'b0;
      timeout_error <= 1'b0;
      pkt_ok_count  <= 8'd0;
      pkt_err_count <= 8'd0;
    end else begin
      frame_error   <= 1'b0;
      timeout_error <= 1'b0;
      // One read in flight at a time: strobe, then capture, then the next strobe.
      pending   <= fifo_read;
      fifo_read <= fetch_state && !fifo_empty && !fifo_read && !pending;
      if (counting)
        tmo <= tmo + TW'(1);

      if (abort || tmo_fire) begin
        frame_error   <= 1'b1;
        timeout_error <= tmo_fire;
        if (pkt_err_count != 8'hFF)
          pkt_err_count <= pkt_err_count + 8'd1;
        tmo   <= '0;
        state <= HUNT;
      end else begin
        case (state)
          HUNT: begin
            if (pending && !byte_err && rx_data == SOF_BYTE) begin
              chk   <= 8'd0;
              tmo   <= '0;
              state <= GET_LEN;
            end
          end
          GET_LEN: begin
            if (pending) begin
              len   <= rx_data;
              chk   <= rx_data;
              idx   <= 8'd0;
              tmo   <= '0;
              state <= GET_PAY;
            end
          end
          GET_PAY: begin
            if (pending) begin
              chk <= chk ^ rx_data;
              idx <= idx_inc;
              tmo <= '0;
              if (idx == len_m1)
                state <= GET_CHK;
            end
          end
          GET_CHK: begin
            if (pending) begin
              if (pkt_ok_count != 8'hFF)
                pkt_ok_count <= pkt_ok_count + 8'd1;
              idx       <= 8'd0;
              tmo       <= '0;
              pkt_data  <= buf_mem[{AW{1'b0}}];
              pkt_valid <= 1'b1;
              pkt_last  <= (len == 8'd1);
              pkt_len   <= len;
              state     <= SEND;
            end
          end
          SEND: begin
            if (pkt_valid && pkt_ready) begin
              if (pkt_last) begin
                pkt_valid <= 1'b0;
                pkt_last  <= 1'b0;
                pkt_data  <= 8'd0;
                state     <= HUNT;
              end else begin
                idx      <= idx_inc;
                pkt_data <= buf_mem[idx_inc[AW-1:0]];
                pkt_last <= (idx_inc == len_m1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
